// File: rtl/apb_event_arbiter_if.sv
// APB requester-side signal bundle for the event arbiter.
// Handshake: a transfer is offered while psel_o=1; it completes on the first clk edge where psel_o, penable_o and pready_i are all 1.
interface apb_event_arbiter_if;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] paddr_o;
  logic [31:0] pwdata_o;
  logic        pready_i;

  modport master (
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
    input  pready_i
  );

  modport slave (
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
    output pready_i
  );
endinterface

// File: rtl/apb_event_arbiter.sv
// Turns rising edges on four event lines into round-robin APB writes of a
// per-source sequence word, with sticky overflow flags for lost events.
module apb_event_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3:0]                 req_i,
  apb_event_arbiter_if.master        apb,
  output logic [3:0]                 grant_o,
  output logic [3:0]                 pending_o,
  output logic [3:0]                 overflow_o,
  output logic [1:0]                 dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  req_q;
  logic [3:0]  evt;
  logic [3:0]  pending;
  logic [3:0]  pending_next;
  logic [3:0]  overflow;
  logic [3:0]  grant;
  logic [3:0]  clr;
  logic [1:0]  owner;
  logic [1:0]  rr_ptr;
  logic [1:0]  winner;
  logic [1:0]  cand;
  logic        found;
  logic        complete;
  logic [7:0]  seq [4];

  assign evt      = req_i & ~req_q;
  assign complete = (state == ACCESS) && apb.pready_i;
  assign clr      = complete ? (4'b0001 << owner) : 4'b0000;
  // A fresh event on the completing source re-arms it rather than being lost.
  assign pending_next = evt | (pending & ~clr);

  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    cand   = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr + 2'(k);
      if (!found && pending[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|pending) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (apb.pready_i) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // req_q tracks req_i even in reset so a line held high never looks like a new edge.
  always_ff @(posedge clk) begin
    req_q <= req_i;
    if (reset) begin
      pending  <= '0;
      overflow <= '0;
      grant    <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      for (int i = 0; i < 4; i++) seq[i] <= '0;
    end else begin
      pending  <= pending_next;
      overflow <= overflow | (evt & pending & ~clr);
      if (state == IDLE && |pending) begin
        grant <= 4'b0001 << winner;
        owner <= winner;
      end
      if (complete) begin
        seq[owner] <= seq[owner] + 8'd1;
        rr_ptr     <= owner + 2'd1;
        grant      <= '0;
      end
    end
  end

  always_comb begin
    apb.psel_o    = 1'b0;
    apb.penable_o = 1'b0;
    apb.pwrite_o  = 1'b0;
    apb.paddr_o   = '0;
    apb.pwdata_o  = '0;
    if (state == SETUP || state == ACCESS) begin
      apb.psel_o    = 1'b1;
      apb.penable_o = (state == ACCESS);
      apb.pwrite_o  = 1'b1;
      apb.paddr_o   = BASE_ADDR + {28'h0, owner, 2'b00};
      apb.pwdata_o  = {16'h0, seq[owner], 6'h0, owner};
    end
  end

  assign grant_o    = grant;
  assign pending_o  = pending;
  assign overflow_o = overflow;
  assign dbg_state  = state;

endmodule

// File: tb/tb_apb_event_arbiter.sv
// Bench for apb_event_arbiter: transfer-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_apb_event_arbiter;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  grant;
  logic [3:0]  pending;
  logic [3:0]  overflow;
  logic [1:0]  dbg_state;

  apb_event_arbiter_if apb();

  apb_event_arbiter #(.BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_i      (req),
    .apb        (apb),
    .grant_o    (grant),
    .pending_o  (pending),
    .overflow_o (overflow),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Owner is the source holding the bus (-1 when none); m_acc marks the enable phase.
  int          m_owner = -1;
  bit          m_acc   = 1'b0;
  bit          m_valid = 1'b0;
  int          m_rr    = 0;
  logic [3:0]  m_req_q = '0;
  logic [3:0]  m_pend  = '0;
  logic [3:0]  m_ovf   = '0;
  logic [7:0]  m_seq [4];
  logic [31:0] exp_q [$];

  function automatic logic [31:0] word_for(input int s);
    return {16'h0, m_seq[s], 6'h0, 2'(s)};
  endfunction

  always @(posedge clk) begin : model
    logic [3:0] ev;
    logic [3:0] pend_old;
    bit         done;
    if (reset) begin
      m_owner = -1;
      m_acc   = 1'b0;
      m_pend  = '0;
      m_ovf   = '0;
      m_rr    = 0;
      for (int i = 0; i < 4; i++) m_seq[i] = '0;
      exp_q.delete();
      m_valid = 1'b1;
    end else begin
      ev       = req & ~m_req_q;
      pend_old = m_pend;
      done     = (m_owner >= 0) && m_acc && apb.pready_i;
      for (int i = 0; i < 4; i++) begin
        if (ev[i]) begin
          if (m_pend[i] && !(done && m_owner == i)) m_ovf[i] = 1'b1;
          m_pend[i] = 1'b1;
        end else if (done && m_owner == i) begin
          m_pend[i] = 1'b0;
        end
      end
      if (m_owner < 0) begin
        for (int k = 0; k < 4; k++) begin
          if (m_owner < 0 && pend_old[(m_rr + k) % 4]) begin
            m_owner = (m_rr + k) % 4;
            m_acc   = 1'b0;
            exp_q.push_back(word_for(m_owner));
          end
        end
      end else if (!m_acc) begin
        m_acc = 1'b1;
      end else if (apb.pready_i) begin
        m_seq[m_owner] = m_seq[m_owner] + 8'd1;
        m_rr    = (m_owner + 1) % 4;
        m_owner = -1;
        m_acc   = 1'b0;
      end
    end
    m_req_q = req;
  end

  // ---------------- scoreboard / monitor ----------------
  logic [3:0]  setup_log [$];
  logic [7:0]  src0_q [$];
  int          done_cnt [4] = '{0, 0, 0, 0};
  int          acc_run = 0;
  int          last_acc_len = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      bit busy;
      busy = (m_owner >= 0);
      check("psel",     32'(apb.psel_o),    32'(busy));
      check("penable",  32'(apb.penable_o), 32'(busy && m_acc));
      check("pwrite",   32'(apb.pwrite_o),  32'(busy));
      check("paddr",    apb.paddr_o,  busy ? BASE + 32'(4 * m_owner) : 32'h0);
      check("pwdata",   apb.pwdata_o, busy ? word_for(m_owner) : 32'h0);
      check("grant",    32'(grant),    busy ? 32'(4'b0001 << m_owner) : 32'h0);
      check("pending",  32'(pending),  32'(m_pend));
      check("overflow", 32'(overflow), 32'(m_ovf));

      if (apb.psel_o && !apb.penable_o) setup_log.push_back(grant);
      if (apb.psel_o && apb.penable_o) acc_run++;
      else if (acc_run != 0) begin
        last_acc_len = acc_run;
        acc_run = 0;
      end
      if (apb.psel_o && apb.penable_o && apb.pready_i && !reset) begin
        if (exp_q.size() == 0) check("xfer_unexpected", 32'd1, 32'd0);
        else check("xfer_data", apb.pwdata_o, exp_q.pop_front());
        for (int i = 0; i < 4; i++) if (grant[i]) done_cnt[i]++;
        if (grant[0]) src0_q.push_back(apb.pwdata_o[15:8]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int base;
    int c2;
    reset = 1'b1;
    req = '0;
    apb.pready_i = 1'b1;
    cyc(3);
    @(negedge clk);
    check("rst_psel",     32'(apb.psel_o), 32'd0);
    check("rst_grant",    32'(grant),      32'd0);
    check("rst_pending",  32'(pending),    32'd0);
    check("rst_overflow", 32'(overflow),   32'd0);
    check("rst_paddr",    apb.paddr_o,     32'd0);
    reset = 1'b0;
    cyc(2);

    // single event on source 1
    req = 4'b0010;
    cyc(1); @(negedge clk);
    check("a_pending", 32'(pending), 32'h2);
    cyc(1); @(negedge clk);
    check("a_setup_sel", {30'h0, apb.psel_o, apb.penable_o}, 32'h2);
    check("a_paddr",  apb.paddr_o,  32'h0000_1004);
    check("a_pwdata", apb.pwdata_o, 32'h0000_0001);
    check("a_grant",  32'(grant),   32'h2);
    cyc(1); @(negedge clk);
    check("a_access_sel", {30'h0, apb.psel_o, apb.penable_o}, 32'h3);
    cyc(1); @(negedge clk);
    check("a_idle_psel", 32'(apb.psel_o), 32'd0);
    check("a_pending_clr", 32'(pending), 32'd0);
    check("a_overflow", 32'(overflow), 32'd0);
    req = '0;
    cyc(2);

    // simultaneous events, round-robin order, pointer wraps back to 0
    do_reset();
    base = setup_log.size();
    req = 4'b1111;
    cyc(16);
    req = 4'b0000;
    cyc(1);
    req = 4'b1010;
    cyc(10);
    check("b_log_len", 32'(setup_log.size() - base), 32'd6);
    if (setup_log.size() - base == 6) begin
      check("b_grant0", 32'(setup_log[base]),     32'h1);
      check("b_grant1", 32'(setup_log[base + 1]), 32'h2);
      check("b_grant2", 32'(setup_log[base + 2]), 32'h4);
      check("b_grant3", 32'(setup_log[base + 3]), 32'h8);
      check("b_rr_wrap_a", 32'(setup_log[base + 4]), 32'h2);
      check("b_rr_wrap_b", 32'(setup_log[base + 5]), 32'h8);
    end
    req = '0;

    // wait states: three stalled ACCESS cycles, completion on the fourth
    do_reset();
    apb.pready_i = 1'b0;
    req = 4'b0001;
    cyc(4); @(negedge clk);
    check("c_stall_sel", {30'h0, apb.psel_o, apb.penable_o}, 32'h3);
    check("c_stall_paddr", apb.paddr_o, 32'h0000_1000);
    cyc(2);
    apb.pready_i = 1'b1;
    cyc(1);
    req = '0;
    cyc(2); @(negedge clk);
    check("c_access_len", 32'(last_acc_len), 32'd4);

    // overflow: source 2 re-fires while still waiting behind source 0
    do_reset();
    apb.pready_i = 1'b0;
    req = 4'b0001; cyc(1);
    req = 4'b0101; cyc(1);
    req = 4'b0001; cyc(1);
    req = 4'b0101; cyc(1);
    c2 = done_cnt[2];
    apb.pready_i = 1'b1;
    cyc(12); @(negedge clk);
    check("d_overflow", 32'(overflow), 32'h4);
    check("d_src2_xfers", 32'(done_cnt[2] - c2), 32'd1);
    check("d_pending", 32'(pending), 32'd0);
    req = '0;
    cyc(2);

    // sequence counter wrap on source 0
    do_reset();
    base = src0_q.size();
    repeat (257) begin
      req = 4'b0001; cyc(1);
      req = 4'b0000; cyc(5);
    end
    check("e_src0_xfers", 32'(src0_q.size() - base), 32'd257);
    if (src0_q.size() - base == 257) begin
      check("e_seq_255", 32'(src0_q[base + 255]), 32'hFF);
      check("e_seq_256", 32'(src0_q[base + 256]), 32'h00);
    end

    // line held high through reset release, then reset during ACCESS
    reset = 1'b1;
    req = 4'b0001;
    cyc(2);
    reset = 1'b0;
    base = setup_log.size();
    cyc(8); @(negedge clk);
    check("f_no_xfer", 32'(setup_log.size() - base), 32'd0);
    check("f_pending", 32'(pending), 32'd0);
    req = '0; cyc(1);
    apb.pready_i = 1'b0;
    req = 4'b0001;
    cyc(3);
    reset = 1'b1;
    @(negedge clk);
    check("f_in_access", {30'h0, apb.psel_o, apb.penable_o}, 32'h3);
    cyc(1);
    reset = 1'b0;
    @(negedge clk);
    check("f_abort_sel", {30'h0, apb.psel_o, apb.penable_o}, 32'h0);
    check("f_abort_pending", 32'(pending), 32'd0);
    check("f_abort_grant", 32'(grant), 32'd0);
    apb.pready_i = 1'b1;
    req = '0;
    cyc(2);

    // random traffic with occasional reset
    repeat (2500) begin
      req = req ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      apb.pready_i = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    reset = 1'b0;
    req = '0;
    apb.pready_i = 1'b1;
    cyc(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_event_arbiter.md
APB_EVENT_ARBITER -- requirements
Module: apb_event_arbiter

Interface
REQ-001 Parameter: BASE_ADDR, default 32'h0000_1000, base address of the 4-word event register window.
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req_i  input  4  level event lines from 4 sources; only rising edges are events.
REQ-005 Port: psel_o  output  1  APB select.
REQ-006 Port: penable_o  output  1  APB enable.
REQ-007 Port: pwrite_o  output  1  APB write strobe; always 1 when psel_o=1.
REQ-008 Port: paddr_o  output  32  APB address.
REQ-009 Port: pwdata_o  output  32  APB write data.
REQ-010 Port: pready_i  input  1  APB ready from peripheral.
REQ-011 Port: grant_o  output  4  one-hot source currently owning the bus; 0 when idle.
REQ-012 Port: pending_o  output  4  registered pending-event bits.
REQ-013 Port: overflow_o  output  4  sticky per-source lost-event flags.

Function
REQ-014 Edge detection SHALL use a registered copy req_q of req_i; event[i] = req_i[i] & ~req_q[i], sampled each posedge.
REQ-015 An event on source i SHALL set pending[i] at that posedge, visible the following cycle.
REQ-016 An event on source i while pending[i]=1 and not completing that cycle SHALL leave pending[i]=1 and set overflow_o[i]=1.
REQ-017 FSM SHALL have states IDLE, SETUP, ACCESS.
REQ-018 IDLE -> SETUP when pending != 0; winner = first set pending bit searching upward from rr_ptr, wrapping 3->0; winner latched into grant_o.
REQ-019 SETUP: psel_o=1, penable_o=0, pwrite_o=1; always -> ACCESS after one cycle.
REQ-020 ACCESS: psel_o=1, penable_o=1; hold paddr_o/pwdata_o stable; remain while pready_i=0 (no timeout).
REQ-021 ACCESS with pready_i=1 -> IDLE; clear pending[w]; increment seq[w]; rr_ptr <= (w+1) mod 4; grant_o <= 0.
REQ-022 At least one IDLE cycle SHALL separate consecutive transfers.
REQ-023 Event on w in the same cycle its transfer completes SHALL keep pending[w]=1 (new event wins over clear), no overflow.
REQ-024 paddr_o = BASE_ADDR + 4*w during SETUP/ACCESS; 0 otherwise.
REQ-025 pwdata_o = {16'h0, seq[w][7:0], 6'h0, w[1:0]} during SETUP/ACCESS; 0 otherwise; seq[w] is the pre-increment value.
REQ-026 seq[i] SHALL be an 8-bit per-source counter wrapping 255 -> 0.
REQ-027 Events arriving during SETUP/ACCESS SHALL only update pending; grant SHALL not change mid-transfer.
REQ-028 psel_o, penable_o, grant_o SHALL be driven from registered state (no combinational path from req_i or pready_i).

Reset
REQ-029 While reset=1: state=IDLE, psel_o=0, penable_o=0, pwrite_o=0, paddr_o=0, pwdata_o=0, grant_o=0, pending=0, overflow_o=0, seq[*]=0, rr_ptr=0.
REQ-030 While reset=1 req_q SHALL load req_i, so a line held high through reset produces no event after release.
REQ-031 Reset asserted mid-transfer SHALL abort it immediately: next cycle psel_o=0, penable_o=0, pending cleared.

Verification
REQ-032 Single event: req_i=4'b0010 rising, pready_i=1 -> SETUP then ACCESS, paddr_o=32'h0000_1004, pwdata_o=32'h0000_0001, pending_o[1] clears, overflow_o=0.
REQ-033 Simultaneous events: req_i 0->4'b1111, pready_i=1 -> grants in order 0,1,2,3, each a 2-cycle transfer plus 1 IDLE, rr_ptr ends at 0.
REQ-034 Wait states: pready_i=0 for 3 ACCESS cycles -> psel_o/penable_o/paddr_o/pwdata_o held stable 3 cycles, completion on 4th.
REQ-035 Overflow: source 2 rises, falls, rises again before its transfer starts -> overflow_o=4'b0100, only one transfer for source 2.
REQ-036 Sequence wrap: 257 events on source 0 -> 256th transfer pwdata_o[15:8]=8'hFF, 257th pwdata_o[15:8]=8'h00.
REQ-037 Reset: req_i=4'b0001 held during reset release -> no transfer; reset asserted in ACCESS -> psel_o=0 next cycle, pending_o=0.
